// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : palette_pkg
//  Brief    : Shared defaults, beat-geometry helpers and FSM state encoding
//             for the double-buffered palette memory.
//  Revision : 1.0  initial release
// ============================================================================
package palette_pkg;

    localparam int c_DEF_ENTRY_W    = 24;
    localparam int c_DEF_BUS_W      = 16;
    localparam int c_DEF_DEPTH      = 256;
    localparam int c_DEF_READ_PORTS = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    function automatic int calc_nbeats(input int entry_w, input int bus_w);
        return (entry_w + bus_w - 1) / bus_w;
    endfunction

    // Width of the final beat's payload; beat 0 carries the MSBs.
    function automatic int calc_rem(input int entry_w, input int bus_w);
        return entry_w - (calc_nbeats(entry_w, bus_w) - 1) * bus_w;
    endfunction

    function automatic int calc_beat_w(input int nbeats);
        return (nbeats <= 1) ? 1 : $clog2(nbeats);
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_memory_banked_bank.sv
`default_nettype none
// ============================================================================
//  Module   : palette_bank
//  Brief    : One palette bank: NRD registered read ports, one write port.
//  Revision : 1.0  initial release
// ============================================================================
module palette_bank
    import palette_pkg::*;
#(
    parameter int ENTRY_W = c_DEF_ENTRY_W,
    parameter int DEPTH   = c_DEF_DEPTH,
    parameter int NRD     = c_DEF_READ_PORTS + 1,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*IDX_W-1:0]   i_rd_addr,
    output logic [NRD*ENTRY_W-1:0] o_rd_data,
    input  logic                   i_we,
    input  logic [IDX_W-1:0]       i_waddr,
    input  logic [ENTRY_W-1:0]     i_wdata
);

    (* ram_style = "block" *) logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd [NRD];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            // Output register carries the reset; the array itself is never cleared.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rd[p] <= '0;
                end else begin
                    r_rd[p] <= r_mem[i_rd_addr[p*IDX_W +: IDX_W]];
                end
            end
            assign o_rd_data[p*ENTRY_W +: ENTRY_W] = r_rd[p];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/palette_memory_banked.sv
`default_nettype none
// ============================================================================
//  Module   : palette_memory_banked
//  Brief    : Double-buffered palette RAM with beat assembler, vblank-timed
//             bank swap and post-swap back-bank refresh.
//  Revision : 1.0  initial release
// ============================================================================
module palette_memory_banked
    import palette_pkg::*;
#(
    parameter int  ENTRY_W    = c_DEF_ENTRY_W,
    parameter int  BUS_W      = c_DEF_BUS_W,
    parameter int  DEPTH      = c_DEF_DEPTH,
    parameter int  READ_PORTS = c_DEF_READ_PORTS,
    localparam int NBEATS     = calc_nbeats(ENTRY_W, BUS_W),
    localparam int REM        = calc_rem(ENTRY_W, BUS_W),
    localparam int BEAT_W     = calc_beat_w(NBEATS),
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_enable,
    input  logic [IDX_W+BEAT_W-1:0]       write_addr,
    input  logic [BUS_W-1:0]              write_data,
    input  logic                          swap_req,
    input  logic                          vblank,
    input  logic                          err_clear,
    input  logic [READ_PORTS*IDX_W-1:0]   rd_addr,
    output logic [READ_PORTS*ENTRY_W-1:0] rd_data,
    output logic                          write_busy,
    output logic                          swap_pending,
    output logic                          front_bank,
    output logic                          err
);

    localparam int                c_ASM_W     = (NBEATS > 1) ? (NBEATS - 1) * BUS_W : 1;
    localparam int                c_CNT_W     = IDX_W + 1;
    localparam int                c_BANK_RD_W = (READ_PORTS + 1) * ENTRY_W;
    localparam logic [BEAT_W:0]   c_NBEATS    = (BEAT_W + 1)'(NBEATS);
    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_END  = c_CNT_W'(DEPTH);

    state_t               r_state;
    logic                 r_front;
    logic                 r_swap_pending;
    logic                 r_err;
    logic                 r_rd_sel;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_asm_valid;
    logic [IDX_W-1:0]     r_asm_idx;
    logic [BEAT_W-1:0]    r_asm_beat;
    logic [c_ASM_W-1:0]   r_asm_data;

    logic [IDX_W-1:0]     w_idx;
    logic [BEAT_W-1:0]    w_beat;
    logic                 w_copying;
    logic                 w_match;
    logic                 w_commit;
    logic                 w_store;
    logic                 w_restart;
    logic                 w_clear;
    logic                 w_err_set;
    logic [ENTRY_W-1:0]   w_commit_data;
    logic                 w_copy_we;
    logic [IDX_W-1:0]     w_copy_waddr;
    logic [ENTRY_W-1:0]   w_copy_data;
    logic                 w_bank_we;
    logic [IDX_W-1:0]     w_bank_waddr;
    logic [ENTRY_W-1:0]   w_bank_wdata;
    logic [c_BANK_RD_W-1:0] w_bank_rd [2];

    assign w_idx     = write_addr[BEAT_W +: IDX_W];
    assign w_beat    = write_addr[BEAT_W-1:0];
    assign w_copying = (r_state == COPY);
    assign w_match   = r_asm_valid && (w_idx == r_asm_idx) && (w_beat == r_asm_beat);

    always_comb begin
        w_commit  = 1'b0;
        w_store   = 1'b0;
        w_restart = 1'b0;
        w_clear   = 1'b0;
        w_err_set = 1'b0;
        if (write_enable) begin
            if (w_copying || ({1'b0, w_beat} >= c_NBEATS)) begin
                w_err_set = 1'b1;
                w_clear   = w_copying;
            end else if ((w_beat == '0) && (c_LAST_BEAT != '0)) begin
                w_restart = 1'b1;
            end else if ((w_beat == '0) || w_match) begin
                if (w_beat == c_LAST_BEAT) begin
                    w_commit = 1'b1;
                    w_clear  = 1'b1;
                end else begin
                    w_store = 1'b1;
                end
            end else begin
                w_err_set = 1'b1;
                w_clear   = 1'b1;
            end
        end
    end

    generate
        if (NBEATS > 1) begin : g_multi
            assign w_commit_data = {r_asm_data, write_data[REM-1:0]};
        end else begin : g_single
            assign w_commit_data = write_data[ENTRY_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_asm_valid <= 1'b0;
            r_asm_idx   <= '0;
            r_asm_beat  <= '0;
            r_asm_data  <= '0;
        end else if (w_restart) begin
            r_asm_valid <= 1'b1;
            r_asm_idx   <= w_idx;
            r_asm_beat  <= BEAT_W'(1);
            r_asm_data  <= c_ASM_W'(write_data);
        end else if (w_store) begin
            r_asm_beat  <= r_asm_beat + 1'b1;
            r_asm_data  <= (r_asm_data << BUS_W) | c_ASM_W'(write_data);
        end else if (w_clear) begin
            r_asm_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The pending flag is sampled before this cycle's swap_req,
                    // so a same-cycle request waits for the following vblank.
                    if (vblank && r_swap_pending) begin
                        r_front        <= ~r_front;
                        r_swap_pending <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= COPY;
                    end else if (swap_req) begin
                        r_swap_pending <= 1'b1;
                    end
                end
                COPY: begin
                    if (swap_req) begin
                        r_swap_pending <= 1'b1;
                    end
                    if (r_cnt == c_CNT_END) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            r_err    <= (r_err && !err_clear) || w_err_set;
            r_rd_sel <= r_front;
        end
    end

    // Copy write trails its read by one cycle; low-bit wrap at cnt==DEPTH yields DEPTH-1.
    assign w_copy_we    = w_copying && (r_cnt != '0);
    assign w_copy_waddr = r_cnt[IDX_W-1:0] - 1'b1;
    assign w_copy_data  = r_front ? w_bank_rd[1][READ_PORTS*ENTRY_W +: ENTRY_W]
                                  : w_bank_rd[0][READ_PORTS*ENTRY_W +: ENTRY_W];

    assign w_bank_we    = w_commit || w_copy_we;
    assign w_bank_waddr = w_copying ? w_copy_waddr : w_idx;
    assign w_bank_wdata = w_copying ? w_copy_data : w_commit_data;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            palette_bank #(
                .ENTRY_W (ENTRY_W),
                .DEPTH   (DEPTH),
                .NRD     (READ_PORTS + 1),
                .IDX_W   (IDX_W)
            ) u_bank (
                .clk       (clk),
                .rst       (rst),
                .i_rd_addr ({r_cnt[IDX_W-1:0], rd_addr}),
                .o_rd_data (w_bank_rd[b]),
                .i_we      (w_bank_we && (r_front != 1'(b))),
                .i_waddr   (w_bank_waddr),
                .i_wdata   (w_bank_wdata)
            );
        end
    endgenerate

    assign rd_data      = r_rd_sel ? w_bank_rd[1][READ_PORTS*ENTRY_W-1:0]
                                   : w_bank_rd[0][READ_PORTS*ENTRY_W-1:0];
    assign write_busy   = w_copying;
    assign swap_pending = r_swap_pending;
    assign front_bank   = r_front;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_palette_memory_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_palette_memory_banked
//  Brief    : Directed self-checking bench for palette_memory_banked (24/16/256/2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_palette_memory_banked;

    localparam int c_DEPTH = 256;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        write_enable = 1'b0;
    logic [8:0]  write_addr   = '0;
    logic [15:0] write_data   = '0;
    logic        swap_req     = 1'b0;
    logic        vblank       = 1'b0;
    logic        err_clear    = 1'b0;
    logic [15:0] rd_addr      = '0;
    logic [47:0] rd_data;
    logic        write_busy;
    logic        swap_pending;
    logic        front_bank;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;

    always #5 clk = ~clk;

    palette_memory_banked #(
        .ENTRY_W    (24),
        .BUS_W      (16),
        .DEPTH      (c_DEPTH),
        .READ_PORTS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .swap_req     (swap_req),
        .vblank       (vblank),
        .err_clear    (err_clear),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .write_busy   (write_busy),
        .swap_pending (swap_pending),
        .front_bank   (front_bank),
        .err          (err)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_beat(input logic [7:0] idx, input logic beat, input logic [15:0] data);
        write_enable = 1'b1;
        write_addr   = {idx, beat};
        write_data   = data;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic wr_entry(input logic [7:0] idx, input logic [23:0] e);
        wr_beat(idx, 1'b0, e[23:8]);
        wr_beat(idx, 1'b1, {8'h00, e[7:0]});
    endtask

    task automatic rd2(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [23:0] e0, input logic [23:0] e1);
        rd_addr = {a1, a0};
        tick();
        check({tag, "_p0"}, {24'h0, rd_data[23:0]}, {24'h0, e0});
        check({tag, "_p1"}, {24'h0, rd_data[47:24]}, {24'h0, e1});
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic pulse_vblank();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
    endtask

    // Counts samples until write_busy drops; bounded so a stuck copy cannot hang.
    task automatic wait_copy(output int n);
        n = 0;
        while (write_busy && n < 1000) begin
            tick();
            n++;
        end
        check("copy_done", {47'h0, write_busy}, 48'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_rd_data", rd_data, 48'h0);
        check("rst_front",   {47'h0, front_bank},   48'h0);
        check("rst_pending", {47'h0, swap_pending}, 48'h0);
        check("rst_busy",    {47'h0, write_busy},   48'h0);
        check("rst_err",     {47'h0, err},          48'h0);
        rst = 1'b1;
        tick();

        // First swap: entry 5 lands in bank 1, becomes front at vblank.
        wr_entry(8'd5, 24'hAABBCC);
        pulse_swap();
        check("sw1_pending", {47'h0, swap_pending}, 48'h1);
        check("sw1_front_pre", {47'h0, front_bank}, 48'h0);
        pulse_vblank();
        check("sw1_front",   {47'h0, front_bank},   48'h1);
        check("sw1_pend_clr", {47'h0, swap_pending}, 48'h0);
        check("sw1_busy",    {47'h0, write_busy},   48'h1);
        wait_copy(n_cyc);
        check("copy_len", 48'(n_cyc), 48'(c_DEPTH + 1));
        rd2("sw1_rd", 8'd5, 8'd5, 24'hAABBCC, 24'hAABBCC);

        // Partial edit on refreshed back bank; read issued right after swap edge.
        wr_entry(8'd6, 24'h112233);
        wr_entry(8'd0, 24'h0A0B0C);
        pulse_swap();
        pulse_vblank();
        check("sw2_front", {47'h0, front_bank}, 48'h0);
        rd2("sw2_rd", 8'd5, 8'd6, 24'hAABBCC, 24'h112233);
        wait_copy(n_cyc);
        check("copy_len2", 48'(n_cyc), 48'(c_DEPTH));

        // Mismatched index on beat 1 is rejected.
        wr_beat(8'd6, 1'b0, 16'hDEAD);
        wr_beat(8'd7, 1'b1, 16'h0099);
        check("bad_idx_err", {47'h0, err}, 48'h1);
        err_clear = 1'b1;
        wr_beat(8'd3, 1'b1, 16'h0001);
        err_clear = 1'b0;
        check("clr_vs_err", {47'h0, err}, 48'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("err_cleared", {47'h0, err}, 48'h0);

        // Pending swap holds without vblank.
        pulse_swap();
        repeat (100) tick();
        check("hold_pending", {47'h0, swap_pending}, 48'h1);
        check("hold_front",   {47'h0, front_bank},   48'h0);
        pulse_vblank();
        check("sw3_front", {47'h0, front_bank}, 48'h1);
        rd2("sw3_rd", 8'd6, 8'd5, 24'h112233, 24'hAABBCC);

        // Host activity during the copy.
        tick();
        wr_entry(8'd0, 24'h123456);
        check("copy_wr_err", {47'h0, err}, 48'h1);
        pulse_swap();
        check("copy_swreq", {47'h0, swap_pending}, 48'h1);
        pulse_vblank();
        check("copy_vblank_ign", {47'h0, front_bank}, 48'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        wait_copy(n_cyc);
        check("post_copy_pend",  {47'h0, swap_pending}, 48'h1);
        check("post_copy_front", {47'h0, front_bank},   48'h1);
        pulse_vblank();
        check("sw4_front", {47'h0, front_bank}, 48'h0);
        rd2("sw4_rd", 8'd0, 8'd5, 24'h0A0B0C, 24'hAABBCC);
        wait_copy(n_cyc);

        // Same-cycle swap_req and vblank defers; then boundary indices.
        wr_entry(8'd0,   24'h0F0E0D);
        wr_entry(8'd255, 24'hFFEE01);
        swap_req = 1'b1;
        vblank   = 1'b1;
        tick();
        swap_req = 1'b0;
        vblank   = 1'b0;
        check("same_cyc_front", {47'h0, front_bank},   48'h0);
        check("same_cyc_pend",  {47'h0, swap_pending}, 48'h1);
        pulse_vblank();
        check("sw5_front", {47'h0, front_bank}, 48'h1);
        rd2("edge_rd", 8'd0, 8'd255, 24'h0F0E0D, 24'hFFEE01);

        // Reset in the middle of a copy.
        repeat (5) tick();
        pulse_swap();
        wr_beat(8'd9, 1'b0, 16'h1234);
        check("pre_rst_err",  {47'h0, err},          48'h1);
        check("pre_rst_busy", {47'h0, write_busy},   48'h1);
        rst = 1'b0;
        tick();
        check("mid_rst_rd_data", rd_data, 48'h0);
        check("mid_rst_front",   {47'h0, front_bank},   48'h0);
        check("mid_rst_pending", {47'h0, swap_pending}, 48'h0);
        check("mid_rst_busy",    {47'h0, write_busy},   48'h0);
        check("mid_rst_err",     {47'h0, err},          48'h0);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
